receptor_jogada_serial: RTL and testbench
=========================================

// Module: receptor_jogada_serial
// PURPOSE
//  UART receiver (8N1, LSB first) that accepts remote moves as ASCII '1'..'9' and
//  emulates a physical key press on the 9-bit active-low button bus feeding the
//  game datapath (botoes). Opposite end of the board's serial link: the datapath
//  transmits game state, this block receives moves. Output is muxed with the real keys.
// PARAMETERS
//  CLKS_PER_BIT  434  clock cycles per UART bit (50 MHz / 115200)
//  HOLD_CYCLES   100  cycles the emulated key stays pressed; also the released gap after it
//  CNT_W         9    width of the shared cycle counter (>= clog2(max(CLKS_PER_BIT,HOLD_CYCLES)+1))
// PORTS
//  clock      in   1  system clock; all logic on rising edge
//  reset      in   1  synchronous, active-low; 0 on a rising edge = reset
//  enable     in   1  1 = accept characters; 0 = forced to WAIT_IDLE, keys released
//  rx         in   1  asynchronous serial line, idle high
//  botoes     out  9  active-low one-hot key bus; 9'h1FF = no key pressed
//  pronto     out  1  1-cycle pulse: valid move accepted (same cycle botoes first goes low)
//  erro       out  1  1-cycle pulse: framing error or char outside '1'..'9'
//  db_dado    out  8  last byte whose stop bit was sampled (valid or not)
//  db_estado  out  4  current FSM state code (debug)
// BEHAVIOUR
//  - rx through 2-flop synchroniser (rx_s); all decisions use rx_s. 2-cycle input latency.
//  - Reset (reset==0 at edge): state=WAIT_IDLE, counters 0, botoes=9'h1FF, pronto=0,
//    erro=0, db_dado=8'h00. Reset mid-frame/mid-hold aborts immediately, no pulses.
//  - States / codes: WAIT_IDLE 0, IDLE 1, START 2, DATA 3, STOP 4, DECODE 5, HOLD 6, GAP 7.
//  - WAIT_IDLE: needs rx_s==1 for CLKS_PER_BIT consecutive cycles (counter clears on
//    any 0), then -> IDLE. Entered after reset, enable==0, error, GAP. Prevents framing
//    on the middle of a character.
//  - IDLE: rx_s==0 -> START, counter=0.
//  - START: at count CLKS_PER_BIT/2-1 (integer division) resample: rx_s==0 -> DATA,
//    counter=0, bit index=0; rx_s==1 -> IDLE (glitch, no erro).
//  - DATA: every CLKS_PER_BIT cycles shift rx_s into bit[index] (LSB first); after
//    bit 7 -> STOP.
//  - STOP: after CLKS_PER_BIT cycles sample; db_dado<=byte. rx_s==1 -> DECODE;
//    rx_s==0 -> erro pulse next cycle, -> WAIT_IDLE.
//  - DECODE (1 cycle): byte in 8'h31..8'h39 -> botoes[byte-8'h31]=0, others 1,
//    pronto=1 for one cycle, -> HOLD; else erro=1 for one cycle, -> WAIT_IDLE.
//  - HOLD: botoes held for exactly HOLD_CYCLES cycles (incl. first), then
//    botoes=9'h1FF, -> GAP. GAP: HOLD_CYCLES cycles released, -> WAIT_IDLE.
//  - rx ignored in HOLD/GAP; characters arriving then are discarded (remote side
//    must pace moves >= 2*HOLD_CYCLES + 1 char time).
//  - enable==0 in any state: next cycle state=WAIT_IDLE, botoes=9'h1FF, no pulses;
//    partial byte lost. pronto and erro never high together; both 0 except DECODE/STOP exits.
//  - Never more than one botoes bit low (XOR of keys in datapath must see one press).
// TESTING
//  1 reset low 2 cycles, rx=1 -> botoes=9'h1FF, pronto=erro=0, db_estado=0 then 1
//    after CLKS_PER_BIT idle cycles.
//  2 send '5' (8'h35) -> one pronto pulse, botoes=9'b1_1110_1111 for exactly
//    HOLD_CYCLES cycles, then 9'h1FF; db_dado=8'h35.
//  3 send 'A' (8'h41) -> one erro pulse, botoes stays 9'h1FF; then '1' -> botoes=9'h1FE.
//  4 send 8'h33 with stop bit=0 -> erro pulse, no press; after line idles
//    CLKS_PER_BIT, '9' -> botoes=9'h0FF.
//  5 rx low pulse of CLKS_PER_BIT/4 cycles -> no pronto/erro, returns to IDLE;
//    '2' sent during HOLD of a prior '7' -> dropped, only bit6 pressed.
//  6 reset (or enable=0) asserted mid-DATA and mid-HOLD -> botoes=9'h1FF next
//    cycle, state WAIT_IDLE, no pronto/erro.

Source files
------------

// File: rtl/receptor_jogada_serial.sv
// UART 8N1 receiver that turns ASCII '1'..'9' into a timed active-low key press
// on the 9-bit button bus, with a released gap before the next character is accepted.
module receptor_jogada_serial #(
  parameter int CLKS_PER_BIT = 434,
  parameter int HOLD_CYCLES  = 100,
  parameter int CNT_W        = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       rx,
  output logic [8:0] botoes,
  output logic       pronto,
  output logic       erro,
  output logic [7:0] db_dado,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    WAIT_IDLE = 4'd0,
    IDLE      = 4'd1,
    START     = 4'd2,
    DATA      = 4'd3,
    STOP      = 4'd4,
    DECODE    = 4'd5,
    HOLD      = 4'd6,
    GAP       = 4'd7
  } state_t;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic [7:0]       db_dado_n;
  logic [8:0]       botoes_n;
  logic             pronto_n, erro_n;
  logic             rx_meta_p0, rx_s;
  logic             key_valid;
  logic [3:0]       key_idx;

  // Synchroniser stage: rx -> rx_meta_p0 -> rx_s
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_meta_p0 <= 1'b1;
      rx_s       <= 1'b1;
    end else begin
      rx_meta_p0 <= rx;
      rx_s       <= rx_meta_p0;
    end
  end

  // ASCII '1'..'9' have low nibble 1..9, so the key index is nibble-1.
  assign key_valid = (db_dado >= 8'h31) && (db_dado <= 8'h39);
  assign key_idx   = db_dado[3:0] - 4'd1;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    db_dado_n = db_dado;
    botoes_n  = botoes;
    pronto_n  = 1'b0;
    erro_n    = 1'b0;
    if (!enable) begin
      state_n  = WAIT_IDLE;
      cnt_n    = '0;
      botoes_n = 9'h1FF;
    end else begin
      case (state)
        WAIT_IDLE: begin
          // Require a full bit time of idle line so we never frame mid-character.
          if (!rx_s) cnt_n = '0;
          else if (cnt == BIT_LAST) begin
            cnt_n   = '0;
            state_n = IDLE;
          end else cnt_n = cnt + CNT_W'(1);
        end
        IDLE: begin
          if (!rx_s) begin
            cnt_n   = '0;
            state_n = START;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt_n = '0;
            if (!rx_s) begin
              bit_idx_n = 3'd0;
              state_n   = DATA;
            end else state_n = IDLE;
          end else cnt_n = cnt + CNT_W'(1);
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt_n            = '0;
            shreg_n[bit_idx] = rx_s;
            if (bit_idx == 3'd7) state_n = STOP;
            else bit_idx_n = bit_idx + 3'd1;
          end else cnt_n = cnt + CNT_W'(1);
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt_n     = '0;
            db_dado_n = shreg;
            if (rx_s) state_n = DECODE;
            else begin
              erro_n  = 1'b1;
              state_n = WAIT_IDLE;
            end
          end else cnt_n = cnt + CNT_W'(1);
        end
        DECODE: begin
          cnt_n = '0;
          if (key_valid) begin
            botoes_n = ~(9'd1 << key_idx);
            pronto_n = 1'b1;
            state_n  = HOLD;
          end else begin
            erro_n  = 1'b1;
            state_n = WAIT_IDLE;
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt_n    = '0;
            botoes_n = 9'h1FF;
            state_n  = GAP;
          end else cnt_n = cnt + CNT_W'(1);
        end
        GAP: begin
          if (cnt == HOLD_LAST) begin
            cnt_n   = '0;
            state_n = WAIT_IDLE;
          end else cnt_n = cnt + CNT_W'(1);
        end
        default: begin
          cnt_n    = '0;
          botoes_n = 9'h1FF;
          state_n  = WAIT_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= WAIT_IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      botoes  <= 9'h1FF;
      pronto  <= 1'b0;
      erro    <= 1'b0;
      db_dado <= 8'h00;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      botoes  <= botoes_n;
      pronto  <= pronto_n;
      erro    <= erro_n;
      db_dado <= db_dado_n;
    end
  end

  // Shift register holds only data bits; it is fully rewritten every frame.
  always_ff @(posedge clock) begin
    shreg <= shreg_n;
  end

  assign db_estado = state;

endmodule

// File: tb/tb_receptor_jogada_serial.sv
// Directed bench for receptor_jogada_serial: serial moves, bad chars, framing
// errors, glitches, and aborts by reset/enable.
module tb_receptor_jogada_serial;

  localparam int CPB  = 16;
  localparam int HOLD = 100;
  localparam int CW   = 7;
  localparam int SETTLE = 2 * HOLD + 2 * CPB + 20;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic       rx = 1'b1;
  logic [8:0] botoes;
  logic       pronto, erro;
  logic [7:0] db_dado;
  logic [3:0] db_estado;

  int errors = 0;
  int checks = 0;

  int n_pronto, n_erro, n_low, n_multi, n_align, n_both;
  logic [8:0] last_key;

  always #5 clock = ~clock;

  receptor_jogada_serial #(
    .CLKS_PER_BIT(CPB),
    .HOLD_CYCLES (HOLD),
    .CNT_W       (CW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .rx       (rx),
    .botoes   (botoes),
    .pronto   (pronto),
    .erro     (erro),
    .db_dado  (db_dado),
    .db_estado(db_estado)
  );

  // Output activity monitor, sampled 1 ns after each rising edge.
  always @(posedge clock) begin
    #1;
    if (pronto === 1'b1) n_pronto++;
    if (erro === 1'b1) n_erro++;
    if (botoes !== 9'h1FF) begin
      n_low++;
      last_key = botoes;
    end
    if ($countones(~botoes) > 1) n_multi++;
    if (pronto === 1'b1 && botoes !== 9'h1FF) n_align++;
    if (pronto === 1'b1 && erro === 1'b1) n_both++;
  end

  task automatic clear_mon();
    n_pronto = 0; n_erro = 0; n_low = 0; n_multi = 0; n_align = 0; n_both = 0;
    last_key = 9'h1FF;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(CPB);
    end
    rx = stop_bit;
    wait_cycles(CPB);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; rx = 1'b1; enable = 1'b1;
    wait_cycles(2);
    checks++; if (botoes !== 9'h1FF) begin errors++; $display("FAIL reset_botoes got=%h exp=1ff", botoes); end
    checks++; if (pronto !== 1'b0 || erro !== 1'b0) begin errors++; $display("FAIL reset_pulses got=%b%b exp=00", pronto, erro); end
    checks++; if (db_dado !== 8'h00) begin errors++; $display("FAIL reset_dado got=%h exp=00", db_dado); end
    checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", db_estado); end
    reset = 1'b1;
    wait_cycles(CPB - 2);
    checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL wait_idle_early got=%0d exp=0", db_estado); end
    wait_cycles(4);
    checks++; if (db_estado !== 4'd1) begin errors++; $display("FAIL wait_idle_done got=%0d exp=1", db_estado); end
  endtask

  task automatic test_valid_move();
    clear_mon();
    send_byte(8'h35, 1'b1);
    wait_cycles(SETTLE);
    checks++; if (n_pronto !== 1) begin errors++; $display("FAIL move5_pronto got=%0d exp=1", n_pronto); end
    checks++; if (n_align !== 1) begin errors++; $display("FAIL move5_align got=%0d exp=1", n_align); end
    checks++; if (n_low !== HOLD) begin errors++; $display("FAIL move5_hold got=%0d exp=%0d", n_low, HOLD); end
    checks++; if (last_key !== 9'h1EF) begin errors++; $display("FAIL move5_key got=%h exp=1ef", last_key); end
    checks++; if (db_dado !== 8'h35) begin errors++; $display("FAIL move5_dado got=%h exp=35", db_dado); end
    checks++; if (n_erro !== 0) begin errors++; $display("FAIL move5_erro got=%0d exp=0", n_erro); end
    checks++; if (botoes !== 9'h1FF || db_estado !== 4'd1) begin errors++; $display("FAIL move5_after got=%h/%0d exp=1ff/1", botoes, db_estado); end
  endtask

  task automatic test_bad_char();
    clear_mon();
    send_byte(8'h41, 1'b1);
    wait_cycles(3 * CPB);
    checks++; if (n_erro !== 1) begin errors++; $display("FAIL badA_erro got=%0d exp=1", n_erro); end
    checks++; if (n_pronto !== 0 || n_low !== 0) begin errors++; $display("FAIL badA_press got=%0d/%0d exp=0/0", n_pronto, n_low); end
    checks++; if (db_dado !== 8'h41) begin errors++; $display("FAIL badA_dado got=%h exp=41", db_dado); end
    clear_mon();
    send_byte(8'h31, 1'b1);
    wait_cycles(SETTLE);
    checks++; if (last_key !== 9'h1FE || n_pronto !== 1) begin errors++; $display("FAIL move1 got=%h/%0d exp=1fe/1", last_key, n_pronto); end
  endtask

  task automatic test_framing();
    clear_mon();
    send_byte(8'h33, 1'b0);
    wait_cycles(3 * CPB);
    checks++; if (n_erro !== 1) begin errors++; $display("FAIL frame_erro got=%0d exp=1", n_erro); end
    checks++; if (n_pronto !== 0 || n_low !== 0) begin errors++; $display("FAIL frame_press got=%0d/%0d exp=0/0", n_pronto, n_low); end
    checks++; if (db_dado !== 8'h33) begin errors++; $display("FAIL frame_dado got=%h exp=33", db_dado); end
    clear_mon();
    send_byte(8'h39, 1'b1);
    wait_cycles(SETTLE);
    checks++; if (last_key !== 9'h0FF || n_low !== HOLD) begin errors++; $display("FAIL move9 got=%h/%0d exp=0ff/%0d", last_key, n_low, HOLD); end
  endtask

  task automatic test_glitch_and_drop();
    clear_mon();
    rx = 1'b0;
    wait_cycles(CPB / 4);
    rx = 1'b1;
    wait_cycles(2 * CPB);
    checks++; if (n_pronto !== 0 || n_erro !== 0) begin errors++; $display("FAIL glitch_pulses got=%0d/%0d exp=0/0", n_pronto, n_erro); end
    checks++; if (db_estado !== 4'd1) begin errors++; $display("FAIL glitch_state got=%0d exp=1", db_estado); end
    clear_mon();
    send_byte(8'h37, 1'b1);
    send_byte(8'h32, 1'b1);
    wait_cycles(SETTLE);
    checks++; if (n_pronto !== 1 || n_erro !== 0) begin errors++; $display("FAIL drop_pulses got=%0d/%0d exp=1/0", n_pronto, n_erro); end
    checks++; if (last_key !== 9'h1BF || n_low !== HOLD) begin errors++; $display("FAIL drop_key got=%h/%0d exp=1bf/%0d", last_key, n_low, HOLD); end
    checks++; if (db_dado !== 8'h37) begin errors++; $display("FAIL drop_dado got=%h exp=37", db_dado); end
  endtask

  task automatic test_abort();
    // Reset in the middle of the data bits.
    clear_mon();
    rx = 1'b0;
    wait_cycles(3 * CPB);
    checks++; if (db_estado !== 4'd3) begin errors++; $display("FAIL abort_in_data got=%0d exp=3", db_estado); end
    reset = 1'b0; rx = 1'b1;
    wait_cycles(1);
    checks++; if (db_estado !== 4'd0 || botoes !== 9'h1FF) begin errors++; $display("FAIL abort_data_rst got=%0d/%h exp=0/1ff", db_estado, botoes); end
    reset = 1'b1;
    wait_cycles(12 * CPB);
    checks++; if (n_pronto !== 0 || n_erro !== 0 || db_estado !== 4'd1) begin errors++; $display("FAIL abort_data_after got=%0d/%0d/%0d exp=0/0/1", n_pronto, n_erro, db_estado); end
    // Enable drop in the middle of a press.
    clear_mon();
    send_byte(8'h34, 1'b1);
    wait_cycles(20);
    checks++; if (db_estado !== 4'd6 || botoes !== 9'h1F7) begin errors++; $display("FAIL abort_in_hold got=%0d/%h exp=6/1f7", db_estado, botoes); end
    enable = 1'b0;
    wait_cycles(1);
    checks++; if (db_estado !== 4'd0 || botoes !== 9'h1FF || pronto !== 1'b0) begin errors++; $display("FAIL abort_hold_en got=%0d/%h/%b exp=0/1ff/0", db_estado, botoes, pronto); end
    enable = 1'b1;
    wait_cycles(SETTLE);
    checks++; if (n_pronto !== 1 || n_erro !== 0 || n_low >= HOLD) begin errors++; $display("FAIL abort_hold_after got=%0d/%0d/%0d exp=1/0/<%0d", n_pronto, n_erro, n_low, HOLD); end
    // Reset in the middle of a press.
    clear_mon();
    send_byte(8'h38, 1'b1);
    wait_cycles(30);
    checks++; if (botoes !== 9'h17F) begin errors++; $display("FAIL abort_key8 got=%h exp=17f", botoes); end
    reset = 1'b0;
    wait_cycles(1);
    checks++; if (db_estado !== 4'd0 || botoes !== 9'h1FF || db_dado !== 8'h00) begin errors++; $display("FAIL abort_hold_rst got=%0d/%h/%h exp=0/1ff/00", db_estado, botoes, db_dado); end
    reset = 1'b1;
    wait_cycles(SETTLE);
    checks++; if (n_pronto !== 1 || n_erro !== 0 || db_estado !== 4'd1) begin errors++; $display("FAIL abort_rst_after got=%0d/%0d/%0d exp=1/0/1", n_pronto, n_erro, db_estado); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_valid_move();
    test_bad_char();
    test_framing();
    test_glitch_and_drop();
    test_abort();
    checks++; if (n_multi !== 0 || n_both !== 0) begin errors++; $display("FAIL exclusivity got=%0d/%0d exp=0/0", n_multi, n_both); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
